// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// ILLEGAL_TRAP_EN adds the Illegal trap flag.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       LessThan;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
`ifdef ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  // Controller side
  modport master (
    input  op, funct3, funct7b5, Zero, LessThan,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUControl
`ifdef ILLEGAL_TRAP_EN
    , output Illegal
`endif
  );

  // Datapath side
  modport slave (
    output op, funct3, funct7b5, Zero, LessThan,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl
`ifdef ILLEGAL_TRAP_EN
    , input Illegal
`endif
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM (lw/sw/R/I/branch/jal/lui).
// ILLEGAL_TRAP_EN: unknown opcodes park in HALT with Illegal=1 instead of refetching.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t     state, state_nxt;
  logic       run;
  logic       is_store, is_store_nxt;

  logic       pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic [2:0] dec_alu;
  logic       br_taken;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  // State advances only once run is set, so the first FETCH is held one cycle with writes off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      run      <= 1'b0;
      is_store <= 1'b0;
    end else begin
      run      <= 1'b1;
      is_store <= is_store_nxt;
      if (run) state <= state_nxt;
    end
  end

  // ALU operation from funct3; only R-type uses funct7b5 to select sub
  always_comb begin
    dec_alu = ALU_ADD;
    unique case (bus.funct3)
      3'b000:  dec_alu = (state == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  dec_alu = ALU_AND;
      3'b110:  dec_alu = ALU_OR;
      3'b100:  dec_alu = ALU_XOR;
      3'b010:  dec_alu = ALU_SLT;
      3'b011:  dec_alu = ALU_SLTU;
      default: dec_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (bus.funct3)
      3'b000:  br_taken = bus.Zero;
      3'b001:  br_taken = ~bus.Zero;
      3'b100:  br_taken = bus.LessThan;
      3'b101:  br_taken = ~bus.LessThan;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    is_store_nxt = is_store;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    result_src   = 2'b00;
    alu_control  = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
    illegal      = 1'b0;
`endif
    unique case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b01;
        // MEMADR must not look at op, so remember load vs store here
        is_store_nxt = (bus.op == OP_STORE);
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_LUI:            state_nxt = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_nxt = S_HALT;
`else
          default:           state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = dec_alu;
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = dec_alu;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = br_taken;
        state_nxt   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        illegal   = 1'b1;
        state_nxt = S_HALT;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  assign bus.PCWrite    = pc_write  & run;
  assign bus.IRWrite    = ir_write  & run;
  assign bus.RegWrite   = reg_write & run;
  assign bus.MemWrite   = mem_write & run;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
`ifdef ILLEGAL_TRAP_EN
  assign bus.Illegal    = illegal;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller; follows ILLEGAL_TRAP_EN if defined.
module tb_multicycle_controller;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
  localparam logic [13:0] E_FNR   = 14'b0000_0_00_10_10_000;
  localparam logic [13:0] E_F     = 14'b1100_0_00_10_10_000;
  localparam logic [13:0] E_DEC   = 14'b0000_0_01_01_00_000;
  localparam logic [13:0] E_MADR  = 14'b0000_0_10_01_00_000;
  localparam logic [13:0] E_MRD   = 14'b0000_1_00_00_00_000;
  localparam logic [13:0] E_MWR   = 14'b0001_1_00_00_00_000;
  localparam logic [13:0] E_MWB   = 14'b0010_0_00_00_01_000;
  localparam logic [13:0] E_RSUB  = 14'b0000_0_10_00_00_001;
  localparam logic [13:0] E_RXOR  = 14'b0000_0_10_00_00_110;
  localparam logic [13:0] E_ISLTU = 14'b0000_0_10_01_00_100;
  localparam logic [13:0] E_IADD  = 14'b0000_0_10_01_00_000;
  localparam logic [13:0] E_WB    = 14'b0010_0_00_00_00_000;
  localparam logic [13:0] E_BRT   = 14'b1000_0_10_00_00_001;
  localparam logic [13:0] E_BRN   = 14'b0000_0_10_00_00_001;
  localparam logic [13:0] E_JAL   = 14'b1000_0_01_10_00_000;
  localparam logic [13:0] E_LUI   = 14'b0010_0_00_00_11_000;
  localparam logic [13:0] E_HALT  = 14'b0000_0_00_00_00_000;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        lt;
    logic [13:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] actual();
    return {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic lt, input logic [13:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [13:0] exp);
    logic [13:0] a;
    a = actual();
    total++;
    if (a !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, a, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(posedge clk);
    #2;
    rst_n        = v.rst;
    bus.op       = v.op;
    bus.funct3   = v.f3;
    bus.funct7b5 = v.f7;
    bus.Zero     = v.z;
    bus.LessThan = v.lt;
    #2;
    check(nm, v.exp);
  endtask

  task automatic step_simple(input logic r, input logic [6:0] o, input logic [13:0] e,
                             input string nm);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = 3'b000; v.f7 = 1'b0; v.z = 1'b0; v.lt = 1'b0; v.exp = e;
    step(v, nm);
  endtask

`ifdef ILLEGAL_TRAP_EN
  task automatic check_illegal(input string nm, input logic exp);
    total++;
    if (bus.Illegal !== exp) begin
      bad++;
      $display("FAIL %s: Illegal got %b expected %b", nm, bus.Illegal, exp);
    end
  endtask
`endif

  initial begin
    bus.op = R; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.Zero = 1'b0; bus.LessThan = 1'b0;

    // reset state, then first cycle after release with writes gated off
    add(0, R, 3'b000, 1, 0, 0, E_FNR);
    add(1, R, 3'b000, 1, 0, 0, E_FNR);
    // R-type sub, then xor
    add(1, R, 3'b000, 1, 0, 0, E_F);
    add(1, R, 3'b000, 1, 0, 0, E_DEC);
    add(1, R, 3'b000, 1, 0, 0, E_RSUB);
    add(1, R, 3'b000, 1, 0, 0, E_WB);
    add(1, R, 3'b100, 0, 0, 0, E_F);
    add(1, R, 3'b100, 0, 0, 0, E_DEC);
    add(1, R, 3'b100, 0, 0, 0, E_RXOR);
    add(1, R, 3'b100, 0, 0, 0, E_WB);
    // lw then sw; MemWrite must drop in the following FETCH
    add(1, LW, 3'b010, 0, 0, 0, E_F);
    add(1, LW, 3'b010, 0, 0, 0, E_DEC);
    add(1, LW, 3'b010, 0, 0, 0, E_MADR);
    add(1, LW, 3'b010, 0, 0, 0, E_MRD);
    add(1, LW, 3'b010, 0, 0, 0, E_MWB);
    add(1, SW, 3'b010, 0, 0, 0, E_F);
    add(1, SW, 3'b010, 0, 0, 0, E_DEC);
    add(1, SW, 3'b010, 0, 0, 0, E_MADR);
    add(1, SW, 3'b010, 0, 0, 0, E_MWR);
    add(1, SW, 3'b010, 0, 0, 0, E_F);
    // branches: bge LT=1, bge LT=0, beq Z=1, bne Z=1
    add(1, BR, 3'b101, 0, 0, 1, E_DEC);
    add(1, BR, 3'b101, 0, 0, 1, E_BRN);
    add(1, BR, 3'b101, 0, 0, 0, E_F);
    add(1, BR, 3'b101, 0, 0, 0, E_DEC);
    add(1, BR, 3'b101, 0, 0, 0, E_BRT);
    add(1, BR, 3'b000, 0, 1, 0, E_F);
    add(1, BR, 3'b000, 0, 1, 0, E_DEC);
    add(1, BR, 3'b000, 0, 1, 0, E_BRT);
    add(1, BR, 3'b001, 0, 1, 0, E_F);
    add(1, BR, 3'b001, 0, 1, 0, E_DEC);
    add(1, BR, 3'b001, 0, 1, 0, E_BRN);
    // I-type sltiu, then addi with bit30 set (must stay add)
    add(1, I, 3'b011, 0, 0, 0, E_F);
    add(1, I, 3'b011, 0, 0, 0, E_DEC);
    add(1, I, 3'b011, 0, 0, 0, E_ISLTU);
    add(1, I, 3'b011, 0, 0, 0, E_WB);
    add(1, I, 3'b000, 1, 0, 0, E_F);
    add(1, I, 3'b000, 1, 0, 0, E_DEC);
    add(1, I, 3'b000, 1, 0, 0, E_IADD);
    add(1, I, 3'b000, 1, 0, 0, E_WB);
    // jal, lui
    add(1, JL, 3'b000, 0, 0, 0, E_F);
    add(1, JL, 3'b000, 0, 0, 0, E_DEC);
    add(1, JL, 3'b000, 0, 0, 0, E_JAL);
    add(1, JL, 3'b000, 0, 0, 0, E_WB);
    add(1, LU, 3'b000, 0, 0, 0, E_F);
    add(1, LU, 3'b000, 0, 0, 0, E_DEC);
    add(1, LU, 3'b000, 0, 0, 0, E_LUI);
    // lw interrupted by reset in MEMREAD (hand sequence below)
    add(1, LW, 3'b010, 0, 0, 0, E_F);
    add(1, LW, 3'b010, 0, 0, 0, E_DEC);
    add(1, LW, 3'b010, 0, 0, 0, E_MADR);
    add(1, LW, 3'b010, 0, 0, 0, E_MRD);

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // reset asserted mid-MEMREAD takes effect without waiting for a clock
    #2 rst_n = 1'b0;
    #1 check("rst_mid_memread", E_FNR);
    step_simple(1'b1, BAD, E_FNR, "rst_release");
    step_simple(1'b1, BAD, E_F,   "fetch_after_rst");
    step_simple(1'b1, BAD, E_DEC, "decode_bad");
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      step_simple(1'b1, BAD, E_HALT, $sformatf("halt%0d", k));
      check_illegal($sformatf("halt_illegal%0d", k), 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 check("halt_reset", E_FNR);
    check_illegal("halt_reset_illegal", 1'b0);
`else
    step_simple(1'b1, BAD, E_F,   "bad_refetch");
    step_simple(1'b1, BAD, E_DEC, "bad_redecode");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
